// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM port between instruction fetch (IF) and the
// MEM stage. MEM has fixed priority. Each access takes WAIT_CYCLES+1 bus cycles
// plus one response cycle. Read data is registered, and ready is a one-cycle pulse.
// Optional feature: define MEM_ARB_PERF_EN to add stall and IF-starvation counters.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_if_req,
  input  logic [31:0] io_if_addr,
  output logic        io_if_ready,
  output logic [31:0] io_if_rdata,
  input  logic        io_mem_req,
  input  logic        io_mem_we,
  input  logic [3:0]  io_mem_be,
  input  logic [31:0] io_mem_addr,
  input  logic [31:0] io_mem_wdata,
  output logic        io_mem_ready,
  output logic [31:0] io_mem_rdata,
  output logic        io_bus_ce,
  output logic        io_bus_we,
  output logic [3:0]  io_bus_be,
  output logic [19:0] io_bus_addr,
  output logic [31:0] io_bus_wdata,
  input  logic [31:0] io_bus_rdata,
  output logic        io_stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] io_perf_stall_cnt,
  output logic [31:0] io_perf_if_wait
`endif
);

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  // Owner encoding: 0 = IF, 1 = MEM.
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  // Only the SRAM word-address bits are used. The byte offset and upper bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{io_if_addr[31:22], io_if_addr[1:0],
                              io_mem_addr[31:22], io_mem_addr[1:0]};

  // State and latch registers, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= 20'd0;
      wdata_q     <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state logic: grant in IDLE, count wait states in ACCESS, and capture read data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (io_mem_req) begin
          owner_d = 1'b1;
          we_d    = io_mem_we;
          be_d    = io_mem_be;
          addr_d  = io_mem_addr[21:2];
          wdata_d = io_mem_wdata;
          state_d = StAccess;
        end else if (io_if_req) begin
          owner_d = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'hF;
          addr_d  = io_if_addr[21:2];
          wdata_d = 32'd0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == WaitLast) begin
          if (!we_q) begin
            if (owner_q) mem_rdata_d = io_bus_rdata;
            else         if_rdata_d  = io_bus_rdata;
          end
          cnt_d   = 4'd0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are driven only during ACCESS. They are zero otherwise.
  always_comb begin
    io_bus_ce    = 1'b0;
    io_bus_we    = 1'b0;
    io_bus_be    = 4'd0;
    io_bus_addr  = 20'd0;
    io_bus_wdata = 32'd0;
    if (state_q == StAccess) begin
      io_bus_ce    = 1'b1;
      io_bus_we    = we_q;
      io_bus_be    = be_q;
      io_bus_addr  = addr_q;
      io_bus_wdata = wdata_q;
    end
  end

  assign io_if_ready  = (state_q == StResp) && !owner_q;
  assign io_mem_ready = (state_q == StResp) && owner_q;
  assign io_if_rdata  = if_rdata_q;
  assign io_mem_rdata = mem_rdata_q;
  assign io_stall     = (io_if_req & ~io_if_ready) | (io_mem_req & ~io_mem_ready);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_if_wait_q;

  // Performance counters: stalled cycles, and IDLE cycles in which IF lost to MEM.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q   <= 32'd0;
      perf_if_wait_q <= 32'd0;
    end else begin
      if (io_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if ((state_q == StIdle) && io_if_req && io_mem_req) begin
        perf_if_wait_q <= perf_if_wait_q + 32'd1;
      end
    end
  end

  assign io_perf_stall_cnt = perf_stall_q;
  assign io_perf_if_wait   = perf_if_wait_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. The main DUT uses WAIT_CYCLES=1.
// Two auxiliary instances (WAIT_CYCLES=0 and 15) share the address and read-data inputs.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_if_req, io_mem_req, io_mem_we, aux_req;
  logic [31:0] io_if_addr, io_mem_addr, io_mem_wdata, io_bus_rdata;
  logic [3:0]  io_mem_be;
  logic        io_if_ready, io_mem_ready, io_bus_ce, io_bus_we, io_stall;
  logic [31:0] io_if_rdata, io_mem_rdata, io_bus_wdata;
  logic [3:0]  io_bus_be;
  logic [19:0] io_bus_addr;
  // Auxiliary instance outputs.
  logic        a0_if_ready, a0_mem_ready, a0_ce, a0_we, a0_stall;
  logic [31:0] a0_if_rdata, a0_mem_rdata, a0_wdata;
  logic [3:0]  a0_be;
  logic [19:0] a0_addr;
  logic        a15_if_ready, a15_mem_ready, a15_ce, a15_we, a15_stall;
  logic [31:0] a15_if_rdata, a15_mem_rdata, a15_wdata;
  logic [3:0]  a15_be;
  logic [19:0] a15_addr;
  logic        aux_mem_req = 1'b0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_if_wait, a0_ps, a0_pw, a15_ps, a15_pw;
`endif

  always #5 clock = ~clock;

  mem_bus_arbiter #(.WAIT_CYCLES(1)) u_dut (
    .clock(clock), .reset(reset),
    .io_if_req(io_if_req), .io_if_addr(io_if_addr),
    .io_if_ready(io_if_ready), .io_if_rdata(io_if_rdata),
    .io_mem_req(io_mem_req), .io_mem_we(io_mem_we), .io_mem_be(io_mem_be),
    .io_mem_addr(io_mem_addr), .io_mem_wdata(io_mem_wdata),
    .io_mem_ready(io_mem_ready), .io_mem_rdata(io_mem_rdata),
    .io_bus_ce(io_bus_ce), .io_bus_we(io_bus_we), .io_bus_be(io_bus_be),
    .io_bus_addr(io_bus_addr), .io_bus_wdata(io_bus_wdata),
    .io_bus_rdata(io_bus_rdata), .io_stall(io_stall)
`ifdef MEM_ARB_PERF_EN
    , .io_perf_stall_cnt(perf_stall_cnt), .io_perf_if_wait(perf_if_wait)
`endif
  );

  mem_bus_arbiter #(.WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset(reset),
    .io_if_req(aux_req), .io_if_addr(io_if_addr),
    .io_if_ready(a0_if_ready), .io_if_rdata(a0_if_rdata),
    .io_mem_req(aux_mem_req), .io_mem_we(io_mem_we), .io_mem_be(io_mem_be),
    .io_mem_addr(io_mem_addr), .io_mem_wdata(io_mem_wdata),
    .io_mem_ready(a0_mem_ready), .io_mem_rdata(a0_mem_rdata),
    .io_bus_ce(a0_ce), .io_bus_we(a0_we), .io_bus_be(a0_be),
    .io_bus_addr(a0_addr), .io_bus_wdata(a0_wdata),
    .io_bus_rdata(io_bus_rdata), .io_stall(a0_stall)
`ifdef MEM_ARB_PERF_EN
    , .io_perf_stall_cnt(a0_ps), .io_perf_if_wait(a0_pw)
`endif
  );

  mem_bus_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .clock(clock), .reset(reset),
    .io_if_req(aux_req), .io_if_addr(io_if_addr),
    .io_if_ready(a15_if_ready), .io_if_rdata(a15_if_rdata),
    .io_mem_req(aux_mem_req), .io_mem_we(io_mem_we), .io_mem_be(io_mem_be),
    .io_mem_addr(io_mem_addr), .io_mem_wdata(io_mem_wdata),
    .io_mem_ready(a15_mem_ready), .io_mem_rdata(a15_mem_rdata),
    .io_bus_ce(a15_ce), .io_bus_we(a15_we), .io_bus_be(a15_be),
    .io_bus_addr(a15_addr), .io_bus_wdata(a15_wdata),
    .io_bus_rdata(io_bus_rdata), .io_stall(a15_stall)
`ifdef MEM_ARB_PERF_EN
    , .io_perf_stall_cnt(a15_ps), .io_perf_if_wait(a15_pw)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        owner;  // 0 = IF, 1 = MEM
    logic [31:0] rdata;
    int          at;     // absolute cycle of the ready pulse
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every ready pulse on the main DUT must match the queued entry.
  always @(negedge clock) begin
    if (!reset && (io_if_ready || io_mem_ready)) begin
      check("ready_onehot", {31'd0, io_if_ready & io_mem_ready}, 32'd0);
      check("sb_pending", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("ready_owner", {31'd0, io_mem_ready}, {31'd0, sb_e.owner});
        check("ready_cycle", cyc, sb_e.at);
        check("rdata", sb_e.owner ? io_mem_rdata : io_if_rdata, sb_e.rdata);
      end
    end
  end

  int c0;
  int w0_ce_n, w15_ce_n, w0_rdy, w15_rdy;
  logic [31:0] w15_data;
  logic [31:0] exp_mem;

  initial begin
    reset = 1'b1; io_if_req = 1'b0; io_mem_req = 1'b0; io_mem_we = 1'b0; aux_req = 1'b0;
    io_if_addr = '0; io_mem_addr = '0; io_mem_wdata = '0; io_mem_be = '0; io_bus_rdata = '0;
    exp_mem = 32'd0;
    tick(); tick();
    check("rst_ce", {31'd0, io_bus_ce}, 32'd0);
    check("rst_ready", {30'd0, io_if_ready, io_mem_ready}, 32'd0);
    check("rst_if_rdata", io_if_rdata, 32'd0);
    check("rst_bus_addr", {12'd0, io_bus_addr}, 32'd0);
    check("rst_stall", {31'd0, io_stall}, 32'd0);
    reset = 1'b0;
    tick();

    // Single IF read.
    c0 = cyc; io_if_req = 1'b1; io_if_addr = 32'h0000_0010; io_bus_rdata = 32'h2408_0005;
    sb_q.push_back('{1'b0, 32'h2408_0005, c0 + 3});
    #1;
    check("if_stall_c0", {31'd0, io_stall}, 32'd1);
    check("if_ce_c0", {31'd0, io_bus_ce}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("if_ce", {31'd0, io_bus_ce}, {31'd0, k <= 2});
      check("if_stall", {31'd0, io_stall}, {31'd0, k <= 2});
      if (k == 1) begin
        check("if_bus_addr", {12'd0, io_bus_addr}, 32'h0000_0004);
        check("if_bus_be", {28'd0, io_bus_be}, 32'hF);
        check("if_bus_we", {31'd0, io_bus_we}, 32'd0);
      end
    end
    io_if_req = 1'b0;
    tick();

    // MEM load, so that the following store can show that the load value is kept.
    c0 = cyc; io_mem_req = 1'b1; io_mem_we = 1'b0; io_mem_be = 4'hF;
    io_mem_addr = 32'h0000_0200; io_bus_rdata = 32'h1122_3344;
    exp_mem = 32'h1122_3344;
    sb_q.push_back('{1'b1, exp_mem, c0 + 3});
    for (int k = 1; k <= 3; k++) tick();
    io_mem_req = 1'b0;
    tick();

    // MEM store.
    c0 = cyc; io_mem_req = 1'b1; io_mem_we = 1'b1; io_mem_be = 4'b0011;
    io_mem_addr = 32'h0000_0104; io_mem_wdata = 32'hDEAD_BEEF; io_bus_rdata = 32'h5555_AAAA;
    sb_q.push_back('{1'b1, exp_mem, c0 + 3});
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k <= 2) begin
        check("st_we", {31'd0, io_bus_we}, 32'd1);
        check("st_be", {28'd0, io_bus_be}, 32'h3);
        check("st_addr", {12'd0, io_bus_addr}, 32'h0000_0041);
        check("st_wdata", io_bus_wdata, 32'hDEAD_BEEF);
      end else begin
        check("st_resp_idle", {30'd0, io_bus_ce, io_bus_we}, 32'd0);
      end
    end
    io_mem_req = 1'b0; io_mem_we = 1'b0;
    tick();

    // Simultaneous requests: MEM first, then IF.
    c0 = cyc; io_mem_req = 1'b1; io_mem_we = 1'b0; io_mem_be = 4'hF;
    io_mem_addr = 32'h0000_0300; io_if_req = 1'b1; io_if_addr = 32'h0000_0400;
    io_bus_rdata = 32'hCAFE_0001;
    exp_mem = 32'hCAFE_0001;
    sb_q.push_back('{1'b1, 32'hCAFE_0001, c0 + 3});
    sb_q.push_back('{1'b0, 32'hCAFE_0002, c0 + 7});
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) check("sim_mem_addr", {12'd0, io_bus_addr}, 32'h0000_00C0);
      if (k == 3) begin
        io_mem_req = 1'b0; io_bus_rdata = 32'hCAFE_0002;
      end
      if (k == 4) check("sim_idle_ce", {31'd0, io_bus_ce}, 32'd0);
      if (k == 5) check("sim_if_addr", {12'd0, io_bus_addr}, 32'h0000_0100);
    end
    io_if_req = 1'b0;
    tick();
`ifdef MEM_ARB_PERF_EN
    check("perf_if_wait", perf_if_wait, 32'd1);
`endif

    // Reset asserted in the second ACCESS cycle.
    c0 = cyc; io_if_req = 1'b1; io_if_addr = 32'h0000_0020; io_bus_rdata = 32'h7777_0001;
    tick(); tick();
    reset = 1'b1; io_if_req = 1'b0;
    tick();
    check("rst_mid_ce", {31'd0, io_bus_ce}, 32'd0);
    check("rst_mid_ready", {30'd0, io_if_ready, io_mem_ready}, 32'd0);
    check("rst_mid_if_rdata", io_if_rdata, 32'd0);
    check("rst_mid_mem_rdata", io_mem_rdata, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, io_if_ready}, 32'd0);
    c0 = cyc; io_if_req = 1'b1; io_if_addr = 32'h0000_0024; io_bus_rdata = 32'h7777_0002;
    sb_q.push_back('{1'b0, 32'h7777_0002, c0 + 3});
    for (int k = 1; k <= 3; k++) tick();
    io_if_req = 1'b0;
    tick();

    // Wait-state extremes on the auxiliary instances.
    aux_req = 1'b1; io_if_addr = 32'h0000_0040; io_bus_rdata = 32'hA5A5_0F0F;
    w0_ce_n = 0; w15_ce_n = 0; w0_rdy = -1; w15_rdy = -1; w15_data = '0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (w0_rdy < 0) begin
        if (a0_ce) w0_ce_n++;
        if (a0_if_ready) w0_rdy = k;
      end
      if (w15_rdy < 0) begin
        if (a15_ce) w15_ce_n++;
        if (a15_if_ready) begin
          w15_rdy = k; w15_data = a15_if_rdata;
        end
      end
      if (k == 17) aux_req = 1'b0;
    end
    check("w0_ce_cycles", w0_ce_n, 32'd1);
    check("w0_ready_cycle", w0_rdy, 32'd2);
    check("w15_ce_cycles", w15_ce_n, 32'd16);
    check("w15_ready_cycle", w15_rdy, 32'd17);
    check("w15_rdata", w15_data, 32'hA5A5_0F0F);

`ifdef MEM_ARB_PERF_EN
    // Three back-to-back IF reads; stall counts three cycles per access.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("perf_rst", perf_stall_cnt, 32'd0);
    c0 = cyc; io_if_req = 1'b1; io_if_addr = 32'h0000_0080; io_bus_rdata = 32'h0BAD_F00D;
    for (int n = 0; n < 3; n++) sb_q.push_back('{1'b0, 32'h0BAD_F00D, c0 + 3 + 4 * n});
    for (int k = 1; k <= 11; k++) tick();
    io_if_req = 1'b0;
    check("perf_stall_cnt", perf_stall_cnt, 32'd9);
    check("perf_if_wait_b2b", perf_if_wait, 32'd0);
    tick();
`endif

    tick(); tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single off-chip SRAM port between instruction fetch (IF) and the MEM stage of the MIPS32 pipeline. Runs a multi-cycle access sequence with configurable wait states, returns read data with a one-cycle ready pulse, and raises a pipeline stall while any request is outstanding. Sits between the IF/MEM stages and the SRAM pad logic.

## Interface
- WAIT_CYCLES, 1, extra SRAM wait states per access (legal 0..15)
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- io_if_req  input  1  IF read request, held until io_if_ready
- io_if_addr  input  32  IF byte address (word aligned)
- io_if_ready  output  1  one-cycle pulse: IF access complete
- io_if_rdata  output  32  fetched word, valid when io_if_ready
- io_mem_req  input  1  MEM request, held until io_mem_ready
- io_mem_we  input  1  1 = store, 0 = load
- io_mem_be  input  4  byte enables (stores)
- io_mem_addr  input  32  MEM byte address
- io_mem_wdata  input  32  store data
- io_mem_ready  output  1  one-cycle pulse: MEM access complete
- io_mem_rdata  output  32  load word, valid when io_mem_ready
- io_bus_ce  output  1  SRAM chip enable
- io_bus_we  output  1  SRAM write enable
- io_bus_be  output  4  SRAM byte enables
- io_bus_addr  output  20  SRAM word address = addr[21:2]
- io_bus_wdata  output  32  SRAM write data
- io_bus_rdata  input  32  SRAM read data
- io_stall  output  1  pipeline stall

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if io_mem_req -> latch MEM we/be/addr/wdata, owner=MEM, go ACCESS; else if io_if_req -> latch IF addr, we=0, be=4'hF, owner=IF, go ACCESS; else stay.
- Priority fixed: MEM over IF (older instruction wins). Simultaneous requests: MEM served first, IF served on next IDLE.
- ACCESS: io_bus_ce=1, io_bus_we=latched we, bus addr/be/wdata from latches (stable for whole access). Wait counter (4 bits) counts 0..WAIT_CYCLES; on count==WAIT_CYCLES, for reads register io_bus_rdata into owner's rdata register, go RESP.
- RESP: bus idle (ce=0, we=0); pulse owner's ready for exactly one cycle; go IDLE.
- Stores: rdata registers unchanged; ready still pulses.
- io_if_rdata/io_mem_rdata hold last loaded value until next read by that owner.
- io_stall = (io_if_req & ~io_if_ready) | (io_mem_req & ~io_mem_ready), combinational.
- Requester must drop req (or present a new one) the cycle after its ready pulse; arbiter re-samples only in IDLE.
- Request dropped mid-access: access completes, ready still pulses.
- Reset (any state, including mid-ACCESS): state=IDLE, counter=0, latches=0, rdata=0, no ready pulse, bus idle.

## Timing
- Reset values: all outputs 0.
- Request seen in IDLE at cycle 0 -> ACCESS cycles 1..WAIT_CYCLES+1 -> ready high in cycle WAIT_CYCLES+2. WAIT_CYCLES=1: ready at cycle 3, ce high cycles 1-2.
- Back-to-back: next grant in IDLE cycle WAIT_CYCLES+3; throughput one access per WAIT_CYCLES+3 cycles.
- No combinational path from io_bus_rdata to any output.

## Configuration
- MEM_ARB_PERF_EN defined: adds output io_perf_stall_cnt [31:0], increments every cycle io_stall=1, wraps at 2^32, cleared by reset. IF-starvation counter io_perf_if_wait [31:0] increments each IDLE cycle where io_if_req=1 but MEM is granted.
- Undefined: no counters, ports absent.

## Test plan
- Single IF read, WAIT_CYCLES=1, addr 0x0000_0010, bus_rdata 0x2408_0005 -> bus_addr 0x00004, ce cycles 1-2, io_if_ready pulse cycle 3, io_if_rdata=0x2408_0005, io_stall 1 in cycles 0-2.
- MEM store addr 0x0000_0104, be 4'b0011, wdata 0xDEAD_BEEF -> bus_we=1, bus_be=0011, bus_addr 0x00041 for 2 cycles, io_mem_ready cycle 3, io_mem_rdata unchanged.
- IF and MEM request same cycle -> MEM access first (ready cycle 3), IF granted cycle 4, io_if_ready cycle 7.
- WAIT_CYCLES=0 -> ce exactly 1 cycle, ready at cycle 2; WAIT_CYCLES=15 -> ce 16 cycles, ready at cycle 17.
- reset asserted in second ACCESS cycle -> next cycle state IDLE, ce=0, no ready pulse, rdata=0; new IF request after reset completes normally.
- MEM_ARB_PERF_EN: 3 back-to-back IF reads, WAIT_CYCLES=1 -> io_perf_stall_cnt=9; with macro undefined, ports absent and build passes.
